// File: rtl/pe_pkg.sv
// Shared types and saturation limits for the systolic processing element.
package pe_pkg;

  typedef enum logic {
    PE_CHAIN = 1'b0,
    PE_LOCAL = 1'b1
  } pe_mode_e;

  typedef enum logic {
    EMPTY = 1'b0,
    ACCUM = 1'b1
  } pe_state_e;

  function automatic longint sat_max(input int unsigned width);
    return (longint'(1) <<< (width - 1)) - 64'sd1;
  endfunction

  function automatic longint sat_min(input int unsigned width);
    return -(longint'(1) <<< (width - 1));
  endfunction

endpackage

// File: rtl/pe_sat_add.sv
// Signed saturating adder; flags any clamp on ovf_o.
module pe_sat_add
  import pe_pkg::*;
#(
  parameter int unsigned WIDTH = 24
) (
  input  logic signed [WIDTH-1:0] a_i,
  input  logic signed [WIDTH-1:0] b_i,
  output logic signed [WIDTH-1:0] sum_o,
  output logic                    ovf_o
);

  localparam logic signed [WIDTH-1:0] MAX_V = WIDTH'(sat_max(WIDTH));
  localparam logic signed [WIDTH-1:0] MIN_V = WIDTH'(sat_min(WIDTH));

  logic [WIDTH:0] wide;

  always_comb begin
    wide  = {a_i[WIDTH-1], a_i} + {b_i[WIDTH-1], b_i};
    sum_o = wide[WIDTH-1:0];
    ovf_o = 1'b0;
    // Top two bits disagree only when the true sum left the representable range.
    if (wide[WIDTH] != wide[WIDTH-1]) begin
      ovf_o = 1'b1;
      sum_o = wide[WIDTH] ? MIN_V : MAX_V;
    end
  end

endmodule

// File: rtl/systolic_pe.sv
// Two-stage multiply-accumulate PE: stage 1 registers the product, stage 2
// either adds the upstream partial sum (CHAIN) or accumulates locally (LOCAL).
module systolic_pe
  import pe_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned ACC_WIDTH  = 24
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         w_load,
  input  logic signed [DATA_WIDTH-1:0] w_in,
  output logic signed [DATA_WIDTH-1:0] w_out,
  input  logic                         inp_valid_in,
  input  logic signed [DATA_WIDTH-1:0] inp_in,
  output logic                         inp_valid_out,
  output logic signed [DATA_WIDTH-1:0] inp_out,
  input  logic signed [ACC_WIDTH-1:0]  acc_in,
  input  logic                         mode,
  input  logic                         last,
  output logic                         acc_valid_out,
  output logic signed [ACC_WIDTH-1:0]  acc_out,
  output logic                         busy,
  output logic                         ovf
);

  localparam int unsigned PW = 2 * DATA_WIDTH;

  logic signed [DATA_WIDTH-1:0] w_q, inp_q;
  logic                         inp_valid_q;

  logic                         s1_valid_q, s1_last_q;
  pe_mode_e                     s1_mode_q;
  logic signed [PW-1:0]         p_q;
  logic signed [ACC_WIDTH-1:0]  s1_acc_q;

  pe_state_e                    state_q, state_d;
  logic signed [ACC_WIDTH-1:0]  acc_r_q, acc_r_d;
  logic signed [ACC_WIDTH-1:0]  acc_out_q, acc_out_d;
  logic                         acc_valid_q, acc_valid_d;
  logic                         ovf_q, ovf_d;

  logic signed [ACC_WIDTH-1:0]  p_ext, add_b, sum;
  logic                         sum_ovf;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      w_q         <= '0;
      inp_q       <= '0;
      inp_valid_q <= 1'b0;
      s1_valid_q  <= 1'b0;
      s1_last_q   <= 1'b0;
      s1_mode_q   <= PE_CHAIN;
      p_q         <= '0;
      s1_acc_q    <= '0;
    end else begin
      if (w_load) w_q <= w_in;
      inp_q       <= inp_in;
      inp_valid_q <= inp_valid_in;
      s1_valid_q  <= inp_valid_in;
      s1_last_q   <= last;
      s1_mode_q   <= pe_mode_e'(mode);
      // Uses the pre-load weight when w_load and a sample share an edge.
      p_q         <= PW'(inp_in) * PW'(w_q);
      s1_acc_q    <= acc_in;
    end
  end

  assign p_ext = ACC_WIDTH'(p_q);
  assign add_b = (s1_mode_q == PE_CHAIN) ? s1_acc_q : acc_r_q;

  pe_sat_add #(.WIDTH(ACC_WIDTH)) u_sat_add (
    .a_i   (p_ext),
    .b_i   (add_b),
    .sum_o (sum),
    .ovf_o (sum_ovf)
  );

  always_comb begin
    state_d     = state_q;
    acc_r_d     = acc_r_q;
    acc_out_d   = acc_out_q;
    acc_valid_d = 1'b0;
    ovf_d       = ovf_q;
    if (s1_valid_q) begin
      ovf_d = ovf_q | sum_ovf;
      if (s1_mode_q == PE_CHAIN) begin
        acc_out_d   = sum;
        acc_valid_d = 1'b1;
      end else if (s1_last_q) begin
        acc_out_d   = sum;
        acc_valid_d = 1'b1;
        acc_r_d     = '0;
        state_d     = EMPTY;
      end else begin
        acc_r_d = sum;
        state_d = ACCUM;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= EMPTY;
      acc_r_q     <= '0;
      acc_out_q   <= '0;
      acc_valid_q <= 1'b0;
      ovf_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      acc_r_q     <= acc_r_d;
      acc_out_q   <= acc_out_d;
      acc_valid_q <= acc_valid_d;
      ovf_q       <= ovf_d;
    end
  end

  assign w_out         = w_q;
  assign inp_out       = inp_q;
  assign inp_valid_out = inp_valid_q;
  assign acc_out       = acc_out_q;
  assign acc_valid_out = acc_valid_q;
  assign busy          = (state_q == ACCUM);
  assign ovf           = ovf_q;

endmodule

// File: tb/tb_systolic_pe.sv
// Self-checking bench for systolic_pe: vector table plus multi-cycle sequences,
// results matched against a scoreboard queue.
module tb_systolic_pe;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic              rst = 1'b1;
  logic              w_load, inp_valid_in, mode, last;
  logic signed [7:0] w_in, inp_in;
  logic signed [23:0] acc_in;
  logic signed [16:0] acc_in17;

  logic signed [7:0]  w_out, inp_out, w_out17, inp_out17;
  logic               inp_valid_out, acc_valid_out, busy, ovf;
  logic               inp_valid_out17, acc_valid_out17, busy17, ovf17;
  logic signed [23:0] acc_out;
  logic signed [16:0] acc_out17;

  systolic_pe #(.DATA_WIDTH(8), .ACC_WIDTH(24)) u_dut (
    .clk(clk), .rst(rst), .w_load(w_load), .w_in(w_in), .w_out(w_out),
    .inp_valid_in(inp_valid_in), .inp_in(inp_in),
    .inp_valid_out(inp_valid_out), .inp_out(inp_out),
    .acc_in(acc_in), .mode(mode), .last(last),
    .acc_valid_out(acc_valid_out), .acc_out(acc_out), .busy(busy), .ovf(ovf)
  );

  systolic_pe #(.DATA_WIDTH(8), .ACC_WIDTH(17)) u_dut17 (
    .clk(clk), .rst(rst), .w_load(w_load), .w_in(w_in), .w_out(w_out17),
    .inp_valid_in(inp_valid_in), .inp_in(inp_in),
    .inp_valid_out(inp_valid_out17), .inp_out(inp_out17),
    .acc_in(acc_in17), .mode(mode), .last(last),
    .acc_valid_out(acc_valid_out17), .acc_out(acc_out17), .busy(busy17), .ovf(ovf17)
  );

  int     errors = 0;
  int     checks = 0;
  longint sb[$];
  int     pulses = 0;
  int     busy_cnt = 0;
  logic              exp_iv;
  logic signed [7:0] exp_io;

  typedef struct {
    int     w;
    int     x;
    int     a;
    longint exp;
  } vec_t;
  vec_t tbl[5];

  task automatic chk(input string name, input longint act, input longint exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      exp_iv = 1'b0;
      exp_io = '0;
    end else begin
      exp_iv = inp_valid_in;
      exp_io = inp_in;
    end
  end

  always @(negedge clk) begin : monitor
    longint e;
    if (!rst) begin
      chk("fwd_valid", longint'(inp_valid_out), longint'(exp_iv));
      chk("fwd_data", inp_out, exp_io);
      if (busy) busy_cnt++;
      if (acc_valid_out) begin
        pulses++;
        if (sb.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_result: got %0d expected no result", acc_out);
        end else begin
          e = sb.pop_front();
          chk("acc_out", acc_out, e);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1);
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    w_load       = 1'b0;
    inp_valid_in = 1'b0;
    mode         = 1'b0;
    last         = 1'b0;
    inp_in       = '0;
    acc_in       = '0;
    acc_in17     = '0;
  endtask

  task automatic load_w(input int w);
    idle();
    w_load = 1'b1;
    w_in   = 8'(w);
    cyc();
    w_load = 1'b0;
  endtask

  task automatic sample(input logic m, input logic l, input int x, input int a);
    inp_valid_in = 1'b1;
    mode         = m;
    last         = l;
    inp_in       = 8'(x);
    acc_in       = 24'(a);
  endtask

  task automatic drain();
    for (int i = 0; i < 20 && sb.size() != 0; i++) cyc();
    chk("drain", sb.size(), 0);
  endtask

  initial begin
    int b0, p0;
    tbl[0] = '{w: 3,    x: -4,   a: 100,     exp: 88};
    tbl[1] = '{w: -128, x: -128, a: 0,       exp: 16384};
    tbl[2] = '{w: 127,  x: -128, a: -5,      exp: -16261};
    tbl[3] = '{w: 0,    x: 55,   a: -1000,   exp: -1000};
    tbl[4] = '{w: -1,   x: 1,    a: 8388607, exp: 8388606};

    w_in = '0;
    idle();
    repeat (2) @(posedge clk);
    #1;
    chk("rst_w_out", w_out, 0);
    chk("rst_acc_out", acc_out, 0);
    chk("rst_acc_valid", longint'(acc_valid_out), 0);
    chk("rst_busy", longint'(busy), 0);
    chk("rst_ovf", longint'(ovf), 0);
    chk("rst_inp_valid_out", longint'(inp_valid_out), 0);
    rst = 1'b0;

    // CHAIN vectors: 2-cycle latency and single-cycle pulse
    for (int i = 0; i < 5; i++) begin
      load_w(tbl[i].w);
      sample(1'b0, 1'b0, tbl[i].x, tbl[i].a);
      sb.push_back(tbl[i].exp);
      cyc();
      idle();
      chk("lat_c1_valid", longint'(acc_valid_out), 0);
      cyc();
      chk("lat_c2_valid", longint'(acc_valid_out), 1);
      cyc();
      chk("pulse_end_valid", longint'(acc_valid_out), 0);
      drain();
    end
    chk("no_ovf_after_table", longint'(ovf), 0);
    repeat (2) cyc();
    chk("acc_out_hold", acc_out, 8388606);

    // weight load racing with a sample
    load_w(2);
    w_load = 1'b1;
    w_in   = 8'sd5;
    sample(1'b0, 1'b0, 10, 0);
    sb.push_back(20);
    cyc();
    w_load = 1'b0;
    chk("w_out_after_load", w_out, 5);
    sample(1'b0, 1'b0, 10, 0);
    sb.push_back(50);
    cyc();
    idle();
    drain();

    // LOCAL 3-sample dot product
    load_w(-128);
    b0 = busy_cnt;
    p0 = pulses;
    for (int k = 0; k < 3; k++) begin
      sample(1'b1, k == 2, -128, 0);
      if (k == 2) sb.push_back(49152);
      cyc();
    end
    idle();
    drain();
    repeat (3) cyc();
    chk("local_busy_cycles", busy_cnt - b0, 2);
    chk("local_pulses", pulses - p0, 1);
    chk("local_busy_end", longint'(busy), 0);

    // alternating CHAIN/LOCAL, back-to-back
    load_w(2);
    for (int i = 0; i < 6; i++) begin
      if (i % 2 == 0) begin
        sample(1'b0, 1'b0, i + 1, 1000);
        sb.push_back(2 * (i + 1) + 1000);
      end else begin
        sample(1'b1, i == 5, i + 1, 0);
        if (i == 5) sb.push_back(24);
      end
      cyc();
    end
    idle();
    drain();
    cyc();
    chk("alt_busy_end", longint'(busy), 0);

    // reset in the middle of a LOCAL accumulation
    load_w(3);
    sample(1'b1, 1'b0, 2, 0);
    cyc();
    sample(1'b1, 1'b0, 4, 0);
    cyc();
    idle();
    cyc();
    chk("pre_rst_busy", longint'(busy), 1);
    rst = 1'b1;
    #2;
    chk("mid_rst_w_out", w_out, 0);
    chk("mid_rst_acc_out", acc_out, 0);
    chk("mid_rst_busy", longint'(busy), 0);
    chk("mid_rst_inp_valid_out", longint'(inp_valid_out), 0);
    chk("mid_rst_inp_out", inp_out, 0);
    cyc();
    rst = 1'b0;
    load_w(3);
    sample(1'b1, 1'b1, 5, 0);
    sb.push_back(15);
    cyc();
    idle();
    drain();
    chk("post_rst_busy", longint'(busy), 0);

    // saturation: positive on the 17-bit instance, negative on the 24-bit one
    rst = 1'b1;
    cyc();
    rst = 1'b0;
    load_w(127);
    sample(1'b0, 1'b0, 127, 60000);
    acc_in17 = 17'sd60000;
    sb.push_back(76129);
    cyc();
    idle();
    cyc();
    chk("sat17_valid", longint'(acc_valid_out17), 1);
    chk("sat17_acc_out", acc_out17, 65535);
    chk("sat17_ovf", longint'(ovf17), 1);
    chk("wide_no_ovf", longint'(ovf), 0);
    drain();
    sample(1'b0, 1'b0, 1, 0);
    sb.push_back(127);
    cyc();
    idle();
    drain();
    chk("sat17_ovf_sticky", longint'(ovf17), 1);
    sample(1'b0, 1'b0, -128, -8388608);
    sb.push_back(-8388608);
    cyc();
    idle();
    drain();
    chk("neg_sat_ovf", longint'(ovf), 1);

    chk("sb_empty", sb.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
